wb2axi: RTL and testbench

- Non-pipelined Wishbone classic slave to AXI4-lite master bridge: the reverse of the AXI-to-Wishbone bridge.
- Lets a 32-bit Wishbone initiator (debug or boot master) reach 64-bit AXI slaves on the biriscv SoC interconnect.
- Handles one outstanding transaction at a time.
- Each 32-bit access maps to a single 64-bit-aligned AXI beat; address bit 2 selects the lane.

---
 rtl/wb2axi.sv | 146 ++++++++++++++
 tb/tb_wb2axi.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb2axi.sv
// wb2axi: Wishbone classic slave to AXI4-lite master bridge.
// One transaction in flight; each 32-bit Wishbone access becomes a single
// 64-bit AXI beat, with byte-address bit 2 choosing the upper or lower lane.
module wb2axi #(
   parameter int              AW = 12,
   parameter int              IW = 1,
   parameter logic [IW-1:0]   ID = '0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [AW-1:2] i_wb_adr,
   input  logic [31:0]   i_wb_dat,
   input  logic [3:0]    i_wb_sel,
   input  logic          i_wb_we,
   input  logic          i_wb_cyc,
   input  logic          i_wb_stb,
   output logic [31:0]   o_wb_rdt,
   output logic          o_wb_ack,
   output logic          o_wb_err,
   output logic [AW-1:0] o_awaddr,
   output logic [IW-1:0] o_awid,
   output logic          o_awvalid,
   input  logic          i_awready,
   output logic [63:0]   o_wdata,
   output logic [7:0]    o_wstrb,
   output logic          o_wvalid,
   input  logic          i_wready,
   input  logic [1:0]    i_bresp,
   input  logic          i_bvalid,
   output logic          o_bready,
   output logic [AW-1:0] o_araddr,
   output logic [IW-1:0] o_arid,
   output logic          o_arvalid,
   input  logic          i_arready,
   input  logic [63:0]   i_rdata,
   input  logic [1:0]    i_rresp,
   input  logic          i_rvalid,
   output logic          o_rready
);

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP} state_t;

   state_t state, state_nxt;
   logic   hi;          // lane of the transaction in flight
   logic   aborted;     // Wishbone dropped cyc after accept
   logic   done;        // AXI response handshake this cycle
   logic   resp_err;    // that response is SLVERR/DECERR
   logic   accept;
   logic   abort_now;
   logic   aw_done;
   logic   w_done;
   logic   unused_resp_lsb;

   assign o_awid = ID;
   assign o_arid = ID;

   // Only resp[1] distinguishes error from okay.
   assign unused_resp_lsb = ^{i_bresp[0], i_rresp[0]};

   // Not re-accepting while ack/err is visible keeps a held strobe from
   // launching the same request twice.
   assign accept    = i_wb_cyc & i_wb_stb & ~o_wb_ack & ~o_wb_err;
   assign abort_now = aborted | ~i_wb_cyc;
   assign aw_done   = ~o_awvalid | i_awready;
   assign w_done    = ~o_wvalid  | i_wready;

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode and response detection.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_nxt = state;
      done      = 1'b0;
      resp_err  = 1'b0;
      case (state)
         IDLE:  if (accept) state_nxt = i_wb_we ? WADDR : RADDR;
         WADDR: if (aw_done && w_done) state_nxt = WRESP;
         WRESP: if (i_bvalid) begin
            state_nxt = IDLE;
            done      = 1'b1;
            resp_err  = i_bresp[1];
         end
         RADDR: if (i_arready) state_nxt = RRESP;
         RRESP: if (i_rvalid) begin
            state_nxt = IDLE;
            done      = 1'b1;
            resp_err  = i_rresp[1];
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs, completion pulses and the sticky abort flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_awvalid <= 1'b0;
         o_wvalid  <= 1'b0;
         o_bready  <= 1'b0;
         o_arvalid <= 1'b0;
         o_rready  <= 1'b0;
         o_wb_ack  <= 1'b0;
         o_wb_err  <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         o_awvalid <= (state == IDLE && accept && i_wb_we) || (o_awvalid && !i_awready);
         o_wvalid  <= (state == IDLE && accept && i_wb_we) || (o_wvalid  && !i_wready);
         o_bready  <= (state_nxt == WRESP);
         o_arvalid <= (state_nxt == RADDR);
         o_rready  <= (state_nxt == RRESP);
         o_wb_ack  <= done && !resp_err && !abort_now;
         o_wb_err  <= done &&  resp_err && !abort_now;
         aborted   <= (state_nxt != IDLE) && abort_now;
      end
   end

   // Request capture on accept and read-data capture on the R handshake.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hi       <= 1'b0;
         o_awaddr <= '0;
         o_araddr <= '0;
         o_wdata  <= '0;
         o_wstrb  <= '0;
         o_wb_rdt <= '0;
      end else begin
         if (state == IDLE && accept) begin
            hi <= i_wb_adr[2];
            if (i_wb_we) begin
               o_awaddr <= {i_wb_adr, 2'b00};
               o_wdata  <= {2{i_wb_dat}};
               o_wstrb  <= i_wb_adr[2] ? {i_wb_sel, 4'h0} : {4'h0, i_wb_sel};
            end else begin
               o_araddr <= {i_wb_adr, 2'b00};
            end
         end
         if (state == RRESP && i_rvalid)
            o_wb_rdt <= hi ? i_rdata[63:32] : i_rdata[31:0];
      end
   end

endmodule

// File: tb/tb_wb2axi.sv
// tb_wb2axi: self-checking bench for the Wishbone-to-AXI4-lite bridge.
// A word-level reference memory predicts every Wishbone response; a 64-bit
// AXI slave model with programmable wait states answers the bridge.
module tb_wb2axi;
   localparam int AW = 12;
   localparam int IW = 1;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [AW-1:2] i_wb_adr;
   logic [31:0]   i_wb_dat;
   logic [3:0]    i_wb_sel;
   logic          i_wb_we, i_wb_cyc, i_wb_stb;
   logic [31:0]   o_wb_rdt;
   logic          o_wb_ack, o_wb_err;
   logic [AW-1:0] o_awaddr, o_araddr;
   logic [IW-1:0] o_awid, o_arid;
   logic          o_awvalid, i_awready;
   logic [63:0]   o_wdata;
   logic [7:0]    o_wstrb;
   logic          o_wvalid, i_wready;
   logic [1:0]    i_bresp;
   logic          i_bvalid, o_bready;
   logic          o_arvalid, i_arready;
   logic [63:0]   i_rdata;
   logic [1:0]    i_rresp;
   logic          i_rvalid, o_rready;

   wb2axi #(.AW(AW), .IW(IW)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
      .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
      .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
      .o_awaddr(o_awaddr), .o_awid(o_awid), .o_awvalid(o_awvalid), .i_awready(i_awready),
      .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
      .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
      .o_araddr(o_araddr), .o_arid(o_arid), .o_arvalid(o_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit          err;
      logic [31:0] rdt;
   } exp_t;

   exp_t          sb_q[$];
   int            checks = 0;
   int            errors = 0;
   int            resp_cnt = 0;
   int            aw_hi_cnt, w_hi_cnt;
   int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic [1:0]    resp_plan;
   logic [AW-1:0] exp_addr;
   logic [63:0]   exp_wdata;
   logic [7:0]    exp_wstrb;
   logic [AW-1:0] cap_awaddr, cap_araddr;
   logic [63:0]   cap_wdata;
   logic [7:0]    cap_wstrb;
   logic [31:0]   model_rdt;
   logic [31:0]   ref_mem [0:1023];
   logic [63:0]   smem    [0:511];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // AW channel of the slave model.
   initial begin : aw_slave
      int cnt;
      cnt = 0;
      i_awready = 1'b0;
      forever begin
         @(negedge i_clk);
         if (i_awready) i_awready = 1'b0;
         else if (o_awvalid && !i_rst) begin
            if (cnt >= aw_wait) begin
               i_awready = 1'b1; cnt = 0; cap_awaddr = o_awaddr;
               check("awaddr", o_awaddr, exp_addr);
            end else cnt++;
         end else cnt = 0;
      end
   end

   // W channel of the slave model.
   initial begin : w_slave
      int cnt;
      cnt = 0;
      i_wready = 1'b0;
      forever begin
         @(negedge i_clk);
         if (i_wready) i_wready = 1'b0;
         else if (o_wvalid && !i_rst) begin
            if (cnt >= w_wait) begin
               i_wready = 1'b1; cnt = 0; cap_wdata = o_wdata; cap_wstrb = o_wstrb;
               check("wdata", o_wdata, exp_wdata);
               check("wstrb", o_wstrb, exp_wstrb);
            end else cnt++;
         end else cnt = 0;
      end
   end

   // B channel: commits the captured write only on an okay response.
   initial begin : b_slave
      int cnt;
      cnt = 0;
      i_bvalid = 1'b0; i_bresp = 2'b00;
      forever begin
         @(negedge i_clk);
         if (i_bvalid) begin i_bvalid = 1'b0; i_bresp = 2'b00; end
         else if (o_bready && !i_rst) begin
            if (cnt >= b_wait) begin
               i_bvalid = 1'b1; i_bresp = resp_plan; cnt = 0;
               if (!resp_plan[1])
                  for (int b = 0; b < 8; b++)
                     if (cap_wstrb[b]) smem[cap_awaddr[AW-1:3]][8*b +: 8] = cap_wdata[8*b +: 8];
            end else cnt++;
         end else cnt = 0;
      end
   end

   // AR channel of the slave model.
   initial begin : ar_slave
      int cnt;
      cnt = 0;
      i_arready = 1'b0;
      forever begin
         @(negedge i_clk);
         if (i_arready) i_arready = 1'b0;
         else if (o_arvalid && !i_rst) begin
            if (cnt >= ar_wait) begin
               i_arready = 1'b1; cnt = 0; cap_araddr = o_araddr;
               check("araddr", o_araddr, exp_addr);
            end else cnt++;
         end else cnt = 0;
      end
   end

   // R channel of the slave model.
   initial begin : r_slave
      int cnt;
      cnt = 0;
      i_rvalid = 1'b0; i_rresp = 2'b00; i_rdata = '0;
      forever begin
         @(negedge i_clk);
         if (i_rvalid) begin i_rvalid = 1'b0; i_rresp = 2'b00; end
         else if (o_rready && !i_rst) begin
            if (cnt >= r_wait) begin
               i_rvalid = 1'b1; i_rresp = resp_plan; cnt = 0;
               i_rdata = smem[cap_araddr[AW-1:3]];
            end else cnt++;
         end else cnt = 0;
      end
   end

   // Valids must not drop before their handshake; also counts valid-high cycles.
   initial begin : axi_rules
      logic pav, par, pwv, pwr, prv, prr;
      {pav, par, pwv, pwr, prv, prr} = '0;
      forever begin
         @(negedge i_clk);
         #1;
         if (!i_rst) begin
            if (pav && !par) check("awvalid_hold", o_awvalid, 1'b1);
            if (pwv && !pwr) check("wvalid_hold",  o_wvalid,  1'b1);
            if (prv && !prr) check("arvalid_hold", o_arvalid, 1'b1);
         end
         if (o_awvalid) aw_hi_cnt++;
         if (o_wvalid)  w_hi_cnt++;
         {pav, par, pwv, pwr, prv, prr} =
            {o_awvalid, i_awready, o_wvalid, i_wready, o_arvalid, i_arready};
      end
   end

   // Scoreboard monitor: every ack/err consumes one expected response.
   initial begin : wb_monitor
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (o_wb_ack || o_wb_err) begin
            resp_cnt++;
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_resp: ack=%0b err=%0b while no request pending",
                        o_wb_ack, o_wb_err);
            end else begin
               e = sb_q.pop_front();
               check("wb_ack", o_wb_ack, !e.err);
               check("wb_err", o_wb_err, e.err);
               check("wb_rdt", o_wb_rdt, e.rdt);
            end
         end
      end
   end

   // One Wishbone transfer; the expected outcome comes from the word memory.
   task automatic wb_xfer(input bit we, input logic [AW-1:0] badr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [1:0] resp,
                          input int wa, input int ww, input int wr, output int lat);
      exp_t e;
      int   widx;
      widx = int'(badr[AW-1:2]);
      aw_wait = wa; ar_wait = wa; w_wait = ww; b_wait = wr; r_wait = wr;
      resp_plan = resp;
      exp_addr  = {badr[AW-1:2], 2'b00};
      exp_wdata = {dat, dat};
      exp_wstrb = badr[2] ? {sel, 4'h0} : {4'h0, sel};
      if (we) begin
         if (!resp[1])
            for (int b = 0; b < 4; b++)
               if (sel[b]) ref_mem[widx][8*b +: 8] = dat[8*b +: 8];
      end else begin
         model_rdt = ref_mem[widx];
      end
      e.err = resp[1];
      e.rdt = model_rdt;
      sb_q.push_back(e);
      aw_hi_cnt = 0; w_hi_cnt = 0;
      @(negedge i_clk);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
      i_wb_adr = badr[AW-1:2]; i_wb_dat = dat; i_wb_sel = sel;
      lat = 0;
      do begin
         @(negedge i_clk);
         lat++;
      end while (!(o_wb_ack || o_wb_err) && lat < 100);
      if (!(o_wb_ack || o_wb_err)) begin
         checks++; errors++;
         $display("FAIL xfer_timeout: no ack/err within %0d cycles for adr %0h", lat, badr);
         void'(sb_q.pop_front());
      end
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int            lat, rc, n;
      bit            rwe;
      logic [AW-1:0] ra;
      logic [1:0]    rr;
      logic [31:0]   w0, w1;

      i_rst = 1'b1;
      i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0;
      i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      resp_plan = 2'b00; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
      model_rdt = '0;
      for (int j = 0; j < 512; j++) begin
         w0 = $urandom; w1 = $urandom;
         ref_mem[2*j] = w0; ref_mem[2*j+1] = w1;
         smem[j] = {w1, w0};
      end

      repeat (2) @(negedge i_clk);
      check("rst_ctrl", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_wb_ack, o_wb_err}, 0);
      check("rst_rdt", o_wb_rdt, 0);
      check("rst_addr", {o_awaddr, o_araddr}, 0);
      check("rst_wdata", {o_wstrb, o_wdata}, 0);
      check("axi_ids", {o_awid, o_arid}, 0);
      i_rst = 1'b0;

      // Lower-lane full-word write, zero-wait slave.
      wb_xfer(1'b1, 12'h008, 32'hCAFEF00D, 4'hF, 2'b00, 0, 0, 0, lat);
      check("wr_latency", lat, 3);
      check("wr_aw_cycles", aw_hi_cnt, 1);
      check("wr_w_cycles", w_hi_cnt, 1);

      // Upper-lane write with AW stalled five cycles.
      wb_xfer(1'b1, 12'h00C, 32'h12345678, 4'h3, 2'b00, 5, 0, 0, lat);
      check("stall_aw_cycles", aw_hi_cnt, 6);
      check("stall_w_cycles", w_hi_cnt, 1);

      // Lane selection on reads.
      smem[2] = 64'h11112222_33334444;
      ref_mem[5] = 32'h11112222; ref_mem[4] = 32'h33334444;
      wb_xfer(1'b0, 12'h014, '0, 4'h0, 2'b00, 0, 0, 0, lat);
      check("rd_latency", lat, 3);
      check("rd_hi_lane", o_wb_rdt, 32'h11112222);
      wb_xfer(1'b0, 12'h010, '0, 4'h0, 2'b00, 0, 0, 0, lat);
      check("rd_lo_lane", o_wb_rdt, 32'h33334444);

      // Error responses.
      wb_xfer(1'b1, 12'h020, 32'hA5A5A5A5, 4'hF, 2'b10, 0, 1, 0, lat);
      wb_xfer(1'b0, 12'h020, '0, 4'h0, 2'b11, 1, 0, 2, lat);
      wb_xfer(1'b0, 12'h020, '0, 4'h0, 2'b00, 0, 0, 0, lat);

      // Wishbone abort during a stalled AR.
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 4; r_wait = 0;
      resp_plan = 2'b00; exp_addr = 12'h018;
      model_rdt = ref_mem[6];
      rc = resp_cnt;
      @(negedge i_clk);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 10'h006;
      @(negedge i_clk);
      check("abort_arvalid_up", o_arvalid, 1'b1);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      repeat (2) begin
         @(negedge i_clk);
         check("abort_arvalid_kept", o_arvalid, 1'b1);
      end
      n = 0;
      while (!o_rready && n < 50) begin @(negedge i_clk); n++; end
      check("abort_r_reached", o_rready, 1'b1);
      repeat (3) @(negedge i_clk);
      check("abort_idle_ctrl", {o_arvalid, o_rready}, 0);
      check("abort_no_resp", resp_cnt, rc);
      wb_xfer(1'b0, 12'h01C, '0, 4'h0, 2'b00, 0, 0, 0, lat);
      check("after_abort_latency", lat, 3);

      // Asynchronous reset while waiting in WRESP.
      aw_wait = 0; w_wait = 0; b_wait = 3; resp_plan = 2'b00;
      exp_addr = 12'h040; exp_wdata = {2{32'hDEADBEEF}}; exp_wstrb = 8'h0F;
      @(negedge i_clk);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
      i_wb_adr = 10'h010; i_wb_dat = 32'hDEADBEEF; i_wb_sel = 4'hF;
      n = 0;
      while (!o_bready && n < 20) begin @(negedge i_clk); n++; end
      check("rst_bready_reached", o_bready, 1'b1);
      #2 i_rst = 1'b1;
      #1;
      check("async_rst_ctrl", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_wb_ack, o_wb_err}, 0);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
      model_rdt = '0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      wb_xfer(1'b1, 12'h040, 32'h0BADC0DE, 4'hF, 2'b00, 0, 0, 0, lat);
      check("after_rst_latency", lat, 3);
      wb_xfer(1'b0, 12'h040, '0, 4'h0, 2'b00, 0, 0, 0, lat);

      // Randomized mix over a small window so reads hit earlier writes.
      for (int k = 0; k < 40; k++) begin
         rwe = 1'($urandom_range(0, 1));
         ra  = AW'($urandom_range(0, 63) * 4);
         rr  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         wb_xfer(rwe, ra, $urandom, 4'($urandom), rr,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), lat);
      end

      repeat (5) @(negedge i_clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
